pixel_scan_gen: RTL and testbench
=================================

PIXEL_SCAN_GEN -- requirements
Module: pixel_scan_gen

Interface
REQ-001 SHALL have parameter SCREEN_WIDTH, default 512, meaning pixels per line (2..2048).
REQ-002 SHALL have parameter SCREEN_HEIGHT, default 512, meaning lines per frame (2..2048).
REQ-003 SHALL have parameter WORD_LENGTH, default 64, meaning width of the signed fixed-point centre words.
REQ-004 SHALL have parameter PRIME_CYCLES, default 3, meaning idle cycles (1..15) between sof and the first valid pixel, so downstream per-frame constants can settle.
REQ-005 SHALL have parameter RESET_ZOOM, default 1, meaning the active ZOOM value after reset.
REQ-006 SHALL have the following ports, clock and reset first:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request one frame; sampled in IDLE only.
- cfg_update  in  1  one-cycle pulse; captures the cfg_* inputs into shadow registers.
- cfg_zoom  in  32  new zoom.
- cfg_real_center  in  WORD_LENGTH  new real centre, signed.
- cfg_imag_center  in  WORD_LENGTH  new imaginary centre, signed.
- x  out  11  pixel column.
- y  out  11  pixel row.
- pix_valid  out  1  x/y valid.
- pix_ready  in  1  downstream accepts.
- sof  out  1  start-of-frame pulse.
- eol  out  1  last pixel of line.
- eof  out  1  last pixel of frame.
- ZOOM  out  32  active zoom.
- real_center  out  WORD_LENGTH  active real centre.
- imag_center  out  WORD_LENGTH  active imaginary centre.
- busy  out  1  FSM not in IDLE.
- frame_done  out  1  one-cycle pulse after the final transfer.

Function
REQ-007 SHALL implement an FSM with states IDLE, PRIME and SCAN, all registered.
REQ-008 SHALL move from IDLE to PRIME when start=1 in IDLE; start SHALL be ignored in every other state.
REQ-009 SHALL assert sof for exactly the first cycle in PRIME, and SHALL hold pix_valid=0 throughout PRIME.
REQ-010 SHALL on PRIME entry copy the shadow registers into ZOOM/real_center/imag_center and clear pending, if pending=1; active config SHALL change at no other time.
REQ-011 SHALL, on cfg_update, load the shadow registers and set pending in any state. If cfg_update coincides with PRIME entry, the old shadow values are applied and pending stays set, holding the new values.
REQ-012 SHALL remain in PRIME for PRIME_CYCLES cycles, then enter SCAN with x=0, y=0.
REQ-013 SHALL drive pix_valid=1 in SCAN; a transfer is a cycle with pix_valid=1 and pix_ready=1.
REQ-014 SHALL keep x, y, eol and eof stable while pix_valid=1 and pix_ready=0.
REQ-015 SHALL, on a transfer, increment x; when x=SCREEN_WIDTH-1, x SHALL wrap to 0 and y SHALL increment.
REQ-016 SHALL drive eol = pix_valid and x=SCREEN_WIDTH-1, and eof = eol and y=SCREEN_HEIGHT-1, both combinational from registered state.
REQ-017 SHALL, on the eof transfer, leave SCAN, pulse frame_done in the next cycle, and return x and y to 0.
REQ-018 SHALL produce exactly SCREEN_WIDTH*SCREEN_HEIGHT transfers per frame in raster order, with no skipped or duplicated pixels under any pix_ready pattern.
REQ-019 SHALL drive busy=1 in PRIME and SCAN, and busy=0 in IDLE.

Reset
REQ-020 SHALL, while rst_n=0, asynchronously force:
- state=IDLE, x=y=0;
- pix_valid=sof=eol=eof=frame_done=busy=0;
- ZOOM=RESET_ZOOM, real_center=imag_center=0;
- shadow registers=0, pending=0.
REQ-021 SHALL abandon a frame when reset is asserted mid-frame; after release the block SHALL wait in IDLE for start.

Configuration
REQ-022 With macro PIXEL_SCAN_CONTINUOUS_EN defined, the transfer following eof SHALL move the FSM directly to PRIME, giving free-running frames with a sof pulse and a pending-config apply per frame, and start SHALL be used only from IDLE.
REQ-023 Without PIXEL_SCAN_CONTINUOUS_EN, the FSM SHALL return to IDLE after eof and await start.

Verification
REQ-024 The bench SHALL cover the following scenario: SCREEN_WIDTH=4, SCREEN_HEIGHT=3, PRIME_CYCLES=3, pix_ready=1, start pulse -> sof 1 cycle after start, first valid 3 cycles after sof, 12 transfers in raster order, eol at x=3, eof at (3,2), frame_done next cycle, busy=0.
REQ-025 The bench SHALL cover the following scenario: same configuration, pix_ready toggling randomly -> x/y/eol stable while stalled, 12 unique transfers, order unchanged.
REQ-026 The bench SHALL cover the following scenario: cfg_update with cfg_zoom=8 mid-SCAN -> ZOOM unchanged until the next PRIME entry, then 8.
REQ-027 The bench SHALL cover the following scenario: rst_n low at pixel (2,1) -> outputs at reset values immediately, IDLE after release, next start begins at (0,0).
REQ-028 The bench SHALL cover the following scenario: PIXEL_SCAN_CONTINUOUS_EN defined, one start -> consecutive frames, each preceded by sof and PRIME_CYCLES of pix_valid=0.
REQ-029 The bench SHALL cover the following scenario: start asserted during SCAN -> no effect on the frame or its count.

Source files
------------

// File: rtl/pixel_scan_gen.sv
// ---------------------------------------------------------------------------
// pixel_scan_gen
//   Raster pixel-coordinate generator with a ready/valid output stream and
//   frame-synchronous configuration shadowing.
//
//   After a start request the block emits a one-cycle sof, idles for
//   PRIME_CYCLES cycles so that downstream per-frame constants can settle,
//   and then steps x/y through the frame in raster order. x/y advance only
//   on a transfer (pix_valid & pix_ready). Configuration written through
//   cfg_update is held in shadow registers and becomes active only on
//   PRIME entry, so a frame never sees its parameters change mid-scan.
//
//   Optional feature macro: PIXEL_SCAN_CONTINUOUS_EN
//     defined   : the eof transfer re-enters PRIME directly (free-running)
//     undefined : the eof transfer returns to IDLE and waits for start
//
//   Ports
//     clk, rst_n        clock (rising edge), async active-low reset
//     start             frame request, honoured in IDLE only
//     cfg_update        one-cycle pulse capturing cfg_* into the shadows
//     cfg_zoom          new zoom
//     cfg_real_center   new real centre (signed)
//     cfg_imag_center   new imaginary centre (signed)
//     x, y              pixel column / row
//     pix_valid         x/y valid
//     pix_ready         downstream accepts
//     sof               start-of-frame pulse (first PRIME cycle)
//     eol, eof          last pixel of line / frame
//     ZOOM              active zoom
//     real_center       active real centre
//     imag_center       active imaginary centre
//     busy              FSM not in IDLE
//     frame_done        one-cycle pulse after the final transfer
// ---------------------------------------------------------------------------
module pixel_scan_gen #(
  parameter int unsigned SCREEN_WIDTH  = 512,
  parameter int unsigned SCREEN_HEIGHT = 512,
  parameter int unsigned WORD_LENGTH   = 64,
  parameter int unsigned PRIME_CYCLES  = 3,
  parameter logic [31:0] RESET_ZOOM    = 32'd1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          cfg_update,
  input  logic [31:0]                   cfg_zoom,
  input  logic signed [WORD_LENGTH-1:0] cfg_real_center,
  input  logic signed [WORD_LENGTH-1:0] cfg_imag_center,
  output logic [10:0]                   x,
  output logic [10:0]                   y,
  output logic                          pix_valid,
  input  logic                          pix_ready,
  output logic                          sof,
  output logic                          eol,
  output logic                          eof,
  output logic [31:0]                   ZOOM,
  output logic signed [WORD_LENGTH-1:0] real_center,
  output logic signed [WORD_LENGTH-1:0] imag_center,
  output logic                          busy,
  output logic                          frame_done
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRIME,
    ST_SCAN
  } state_t;

  localparam logic [10:0] LP_X_LAST     = 11'(SCREEN_WIDTH - 1);
  localparam logic [10:0] LP_Y_LAST     = 11'(SCREEN_HEIGHT - 1);
  localparam logic [3:0]  LP_PRIME_LAST = 4'(PRIME_CYCLES - 1);

  state_t                        r_state;
  logic [10:0]                   r_x;
  logic [10:0]                   r_y;
  logic                          r_pix_valid;
  logic                          r_sof;
  logic                          r_frame_done;
  logic [3:0]                    r_prime_cnt;
  logic [31:0]                   r_zoom;
  logic signed [WORD_LENGTH-1:0] r_real;
  logic signed [WORD_LENGTH-1:0] r_imag;
  logic [31:0]                   r_sh_zoom;
  logic signed [WORD_LENGTH-1:0] r_sh_real;
  logic signed [WORD_LENGTH-1:0] r_sh_imag;
  logic                          r_pending;

  logic w_xfer;
  logic w_eol;
  logic w_eof;
  logic w_restart;
  logic w_enter_prime;

  assign w_xfer = r_pix_valid & pix_ready;
  assign w_eol  = r_pix_valid & (r_x == LP_X_LAST);
  assign w_eof  = w_eol & (r_y == LP_Y_LAST);

`ifdef PIXEL_SCAN_CONTINUOUS_EN
  assign w_restart = (r_state == ST_SCAN) & w_xfer & w_eof;
`else
  assign w_restart = 1'b0;
`endif

  // Both routes into PRIME share the sof / config-apply handling below.
  assign w_enter_prime = ((r_state == ST_IDLE) & start) | w_restart;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_x          <= '0;
      r_y          <= '0;
      r_pix_valid  <= 1'b0;
      r_sof        <= 1'b0;
      r_frame_done <= 1'b0;
      r_prime_cnt  <= '0;
      r_zoom       <= RESET_ZOOM;
      r_real       <= '0;
      r_imag       <= '0;
      r_sh_zoom    <= '0;
      r_sh_real    <= '0;
      r_sh_imag    <= '0;
      r_pending    <= 1'b0;
    end else begin
      r_sof        <= 1'b0;
      r_frame_done <= 1'b0;

      if (cfg_update) begin
        r_sh_zoom <= cfg_zoom;
        r_sh_real <= cfg_real_center;
        r_sh_imag <= cfg_imag_center;
        r_pending <= 1'b1;
      end

      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_PRIME;
          end
        end
        ST_PRIME: begin
          if (r_prime_cnt == '0) begin
            r_state     <= ST_SCAN;
            r_pix_valid <= 1'b1;
          end else begin
            r_prime_cnt <= r_prime_cnt - 4'd1;
          end
        end
        ST_SCAN: begin
          if (w_xfer) begin
            if (w_eof) begin
              r_x          <= '0;
              r_y          <= '0;
              r_pix_valid  <= 1'b0;
              r_frame_done <= 1'b1;
              r_state      <= w_restart ? ST_PRIME : ST_IDLE;
            end else if (w_eol) begin
              r_x <= '0;
              r_y <= r_y + 11'd1;
            end else begin
              r_x <= r_x + 11'd1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase

      // Apply uses the shadow contents from before this edge; a coincident
      // cfg_update therefore stays pending (its set above is re-asserted).
      if (w_enter_prime) begin
        r_sof       <= 1'b1;
        r_prime_cnt <= LP_PRIME_LAST;
        if (r_pending) begin
          r_zoom    <= r_sh_zoom;
          r_real    <= r_sh_real;
          r_imag    <= r_sh_imag;
          r_pending <= cfg_update;
        end
      end
    end
  end

  assign x           = r_x;
  assign y           = r_y;
  assign pix_valid   = r_pix_valid;
  assign sof         = r_sof;
  assign eol         = w_eol;
  assign eof         = w_eof;
  assign ZOOM        = r_zoom;
  assign real_center = r_real;
  assign imag_center = r_imag;
  assign busy        = (r_state != ST_IDLE);
  assign frame_done  = r_frame_done;

endmodule

// File: tb/tb_pixel_scan_gen.sv
// ---------------------------------------------------------------------------
// tb_pixel_scan_gen
//   Scoreboard bench for pixel_scan_gen on a 4x3 screen, PRIME_CYCLES=3.
//   Stimulus pushes the expected raster sequence into a queue; a monitor on
//   the falling edge pops and compares on every transfer and also checks
//   that x/y/eol/eof hold while stalled. Inputs change 1 time unit after
//   the rising edge. With PIXEL_SCAN_CONTINUOUS_EN defined the free-running
//   sequence is exercised instead of the start-per-frame sequence.
// ---------------------------------------------------------------------------
module tb_pixel_scan_gen;

  localparam int unsigned W  = 4;
  localparam int unsigned H  = 3;
  localparam int unsigned WL = 64;

  logic                 clk;
  logic                 rst_n;
  logic                 start;
  logic                 cfg_update;
  logic [31:0]          cfg_zoom;
  logic signed [WL-1:0] cfg_real_center;
  logic signed [WL-1:0] cfg_imag_center;
  logic [10:0]          x;
  logic [10:0]          y;
  logic                 pix_valid;
  logic                 pix_ready;
  logic                 sof;
  logic                 eol;
  logic                 eof;
  logic [31:0]          ZOOM;
  logic signed [WL-1:0] real_center;
  logic signed [WL-1:0] imag_center;
  logic                 busy;
  logic                 frame_done;

  pixel_scan_gen #(
    .SCREEN_WIDTH (W),
    .SCREEN_HEIGHT(H),
    .WORD_LENGTH  (WL),
    .PRIME_CYCLES (3),
    .RESET_ZOOM   (32'd1)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .cfg_update     (cfg_update),
    .cfg_zoom       (cfg_zoom),
    .cfg_real_center(cfg_real_center),
    .cfg_imag_center(cfg_imag_center),
    .x              (x),
    .y              (y),
    .pix_valid      (pix_valid),
    .pix_ready      (pix_ready),
    .sof            (sof),
    .eol            (eol),
    .eof            (eof),
    .ZOOM           (ZOOM),
    .real_center    (real_center),
    .imag_center    (imag_center),
    .busy           (busy),
    .frame_done     (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [10:0] px;
    logic [10:0] py;
    logic        peol;
    logic        peof;
  } pix_t;

  pix_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame();
    pix_t e;
    for (int yy = 0; yy < int'(H); yy++) begin
      for (int xx = 0; xx < int'(W); xx++) begin
        e.px   = 11'(xx);
        e.py   = 11'(yy);
        e.peol = (xx == int'(W) - 1);
        e.peof = (xx == int'(W) - 1) && (yy == int'(H) - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  // Called in the sof cycle: checks the PRIME window and the first pixel.
  task automatic check_prime_from_sof(input logic [31:0] exp_zoom);
    chk("sof high", 64'(sof), 64'd1);
    chk("busy in prime", 64'(busy), 64'd1);
    chk("valid low prime1", 64'(pix_valid), 64'd0);
    chk("zoom at sof", 64'(ZOOM), 64'(exp_zoom));
    tick();
    chk("sof one cycle", 64'(sof), 64'd0);
    chk("valid low prime2", 64'(pix_valid), 64'd0);
    tick();
    chk("valid low prime3", 64'(pix_valid), 64'd0);
    tick();
    chk("first valid", 64'(pix_valid), 64'd1);
    chk("first x", 64'(x), 64'd0);
    chk("first y", 64'(y), 64'd0);
  endtask

  task automatic run_prime(input logic [31:0] exp_zoom);
    start = 1'b1;
    tick();
    start      = 1'b0;
    cfg_update = 1'b0;
    check_prime_from_sof(exp_zoom);
  endtask

  task automatic wait_frame_done();
    for (int i = 0; i < 200 && !frame_done; i++) tick();
    chk("frame_done seen", 64'(frame_done), 64'd1);
  endtask

  task automatic wait_sof();
    for (int i = 0; i < 60 && !sof; i++) tick();
    chk("sof seen", 64'(sof), 64'd1);
  endtask

  // Monitor: pops the scoreboard on each transfer, checks stall hold.
  initial begin : monitor
    pix_t        e;
    logic        h_stall;
    logic [10:0] h_x;
    logic [10:0] h_y;
    logic        h_eol;
    logic        h_eof;
    h_stall = 1'b0;
    h_x = '0; h_y = '0; h_eol = 1'b0; h_eof = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        h_stall = 1'b0;
      end else begin
        if (h_stall) begin
          chk("stall valid", 64'(pix_valid), 64'd1);
          chk("stall x", 64'(x), 64'(h_x));
          chk("stall y", 64'(y), 64'(h_y));
          chk("stall eol", 64'(eol), 64'(h_eol));
          chk("stall eof", 64'(eof), 64'(h_eof));
        end
        if (pix_valid && pix_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected transfer: actual (%0d,%0d) required none", x, y);
          end else begin
            e = exp_q.pop_front();
            chk("px x", 64'(x), 64'(e.px));
            chk("px y", 64'(y), 64'(e.py));
            chk("px eol", 64'(eol), 64'(e.peol));
            chk("px eof", 64'(eof), 64'(e.peof));
          end
        end
        h_stall = pix_valid && !pix_ready;
        h_x     = x;
        h_y     = y;
        h_eol   = eol;
        h_eof   = eof;
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [15:0] pat;
    pat = 16'b1011_0010_1110_0101;
    rst_n = 1'b0;
    start = 1'b0;
    cfg_update = 1'b0;
    cfg_zoom = '0;
    cfg_real_center = '0;
    cfg_imag_center = '0;
    pix_ready = 1'b1;
    tick();
    tick();
    chk("rst x", 64'(x), 64'd0);
    chk("rst y", 64'(y), 64'd0);
    chk("rst valid", 64'(pix_valid), 64'd0);
    chk("rst sof", 64'(sof), 64'd0);
    chk("rst eol", 64'(eol), 64'd0);
    chk("rst eof", 64'(eof), 64'd0);
    chk("rst frame_done", 64'(frame_done), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst zoom", 64'(ZOOM), 64'd1);
    chk("rst real", 64'(real_center), 64'd0);
    chk("rst imag", 64'(imag_center), 64'd0);
    rst_n = 1'b1;
    tick();
    tick();
    chk("idle busy", 64'(busy), 64'd0);

`ifdef PIXEL_SCAN_CONTINUOUS_EN
    // Free-running: one start, two full frames, cfg applied at second sof.
    push_frame();
    push_frame();
    run_prime(32'd1);
    chk("frame_done at first sof", 64'(frame_done), 64'd0);
    cfg_zoom   = 32'd7;
    cfg_update = 1'b1;
    tick();
    cfg_update = 1'b0;
    chk("zoom held mid frame", 64'(ZOOM), 64'd1);
    wait_sof();
    chk("frame_done at second sof", 64'(frame_done), 64'd1);
    check_prime_from_sof(32'd7);
    wait_sof();
    chk("busy free running", 64'(busy), 64'd1);
    chk("two frames drained", 64'(exp_q.size()), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("reset stops busy", 64'(busy), 64'd0);
    chk("reset stops valid", 64'(pix_valid), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
`else
    // Frame 1: ready held high.
    pix_ready = 1'b1;
    push_frame();
    run_prime(32'd1);
    wait_frame_done();
    chk("busy after frame", 64'(busy), 64'd0);
    chk("valid after frame", 64'(pix_valid), 64'd0);
    chk("frame1 drained", 64'(exp_q.size()), 64'd0);
    tick();
    chk("frame_done one cycle", 64'(frame_done), 64'd0);

    // Frame 2: stalls from a fixed ready pattern.
    pix_ready = 1'b0;
    push_frame();
    run_prime(32'd1);
    for (int i = 0; i < 200 && !frame_done; i++) begin
      pix_ready = pat[i % 16];
      tick();
    end
    chk("stalled frame_done", 64'(frame_done), 64'd1);
    chk("frame2 drained", 64'(exp_q.size()), 64'd0);
    pix_ready = 1'b1;
    tick();

    // Frame 3: cfg_update and start while scanning.
    push_frame();
    run_prime(32'd1);
    cfg_zoom        = 32'd8;
    cfg_real_center = 64'sd5;
    cfg_imag_center = -64'sd3;
    cfg_update      = 1'b1;
    start           = 1'b1;
    tick();
    cfg_update = 1'b0;
    chk("zoom held scan a", 64'(ZOOM), 64'd1);
    tick();
    start = 1'b0;
    chk("zoom held scan b", 64'(ZOOM), 64'd1);
    wait_frame_done();
    chk("zoom held to end", 64'(ZOOM), 64'd1);
    chk("frame3 drained", 64'(exp_q.size()), 64'd0);
    tick();
    tick();
    chk("start in scan ignored", 64'(busy), 64'd0);

    // Frame 4: new config applied, reset mid-frame at (2,1).
    push_frame();
    run_prime(32'd8);
    chk("real applied", 64'(real_center), 64'd5);
    chk("imag applied", 64'(imag_center), 64'hFFFF_FFFF_FFFF_FFFD);
    for (int i = 0; i < 30 && !(pix_valid && x == 11'd2 && y == 11'd1); i++) tick();
    chk("reached (2,1) x", 64'(x), 64'd2);
    chk("reached (2,1) y", 64'(y), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst x", 64'(x), 64'd0);
    chk("midrst y", 64'(y), 64'd0);
    chk("midrst valid", 64'(pix_valid), 64'd0);
    chk("midrst eol", 64'(eol), 64'd0);
    chk("midrst busy", 64'(busy), 64'd0);
    chk("midrst zoom", 64'(ZOOM), 64'd1);
    chk("midrst real", 64'(real_center), 64'd0);
    chk("abandoned pixels left", 64'(exp_q.size()), 64'd6);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    chk("idle after reset", 64'(busy), 64'd0);
    chk("no valid after reset", 64'(pix_valid), 64'd0);

    // Pending shadow (9) applied; coincident update (20) stays pending.
    cfg_zoom   = 32'd9;
    cfg_update = 1'b1;
    tick();
    cfg_update = 1'b0;
    chk("zoom held in idle", 64'(ZOOM), 64'd1);
    push_frame();
    cfg_zoom   = 32'd20;
    cfg_update = 1'b1;
    run_prime(32'd9);
    wait_frame_done();
    chk("frame5 drained", 64'(exp_q.size()), 64'd0);
    tick();
    push_frame();
    run_prime(32'd20);
    wait_frame_done();
    chk("frame6 drained", 64'(exp_q.size()), 64'd0);
    tick();
`endif

    tick();
    chk("final queue empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_cmp, n_err);
    $finish;
  end

endmodule
